// File: rtl/pd_dbg_pkg.sv
// Shared types and widths for the pattern-generator debug RAM arbiter.
package pd_dbg_pkg;

  localparam int PD_DBG_ADDR_W = 4;
  localparam int PD_DBG_DATA_W = 32;
  localparam int PD_DBG_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } pd_dbg_arb_state_t;

endpackage

// File: rtl/pd_debug_ram_arbiter_if.sv
// Requester-side and RAM-port-s1 signal bundle for pd_debug_ram_arbiter.
// The freeze input exists only when PD_DBG_ARB_FREEZE_EN is defined.
interface pd_debug_ram_arbiter_if
  import pd_dbg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = PD_DBG_ADDR_W,
  parameter int DATA_W  = PD_DBG_DATA_W
) ();
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         ram_address;
  logic [BE_W-1:0]           ram_byteenable;
  logic                      ram_chipselect;
  logic                      ram_write;
  logic [DATA_W-1:0]         ram_writedata;
  logic [DATA_W-1:0]         ram_readdata;

`ifdef PD_DBG_ARB_FREEZE_EN
  logic freeze;

  modport slave (
    input  req, req_write, req_address, req_byteenable, req_writedata, freeze, ram_readdata,
    output ack, rvalid, rdata, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );
  modport master (
    output req, req_write, req_address, req_byteenable, req_writedata, freeze, ram_readdata,
    input  ack, rvalid, rdata, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );
`else
  modport slave (
    input  req, req_write, req_address, req_byteenable, req_writedata, ram_readdata,
    output ack, rvalid, rdata, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );
  modport master (
    output req, req_write, req_address, req_byteenable, req_writedata, ram_readdata,
    input  ack, rvalid, rdata, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata
  );
`endif

endinterface

// File: rtl/pd_rr_arbiter.sv
// Combinational round-robin pick: first eligible index after last_grant, wrapping.
module pd_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin : pick
    int c;
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    c         = 0;
    // Scan offsets 1..N so last_grant itself is considered last.
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_grant) + k) % N;
      if (!any_grant && elig[c]) begin
        any_grant   = 1'b1;
        grant_idx   = IW'(c);
        grant_oh[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pd_debug_ram_arbiter.sv
// Round-robin sequencer sharing debug RAM port s1 between NUM_REQ requesters.
// Optional write-freeze input is compiled in with PD_DBG_ARB_FREEZE_EN.
module pd_debug_ram_arbiter
  import pd_dbg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = PD_DBG_ADDR_W,
  parameter int DATA_W  = PD_DBG_DATA_W
) (
  input logic clk,
  input logic reset,
  pd_debug_ram_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  pd_dbg_arb_state_t   state_q, state_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [BE_W-1:0]     ram_byteenable_q, ram_byteenable_d;
  logic [DATA_W-1:0]   ram_writedata_q, ram_writedata_d;
  logic                ram_write_q, ram_write_d;
  logic                ram_cs_q, ram_cs_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                any_grant;

`ifdef PD_DBG_ARB_FREEZE_EN
  // Frozen writes are simply invisible to the arbiter, so the pointer only moves on real grants.
  assign elig = bus.req & ~(bus.req_write & {NUM_REQ{bus.freeze}});
`else
  assign elig = bus.req;
`endif

  pd_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .elig       (elig),
    .last_grant (last_grant_q),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any_grant  (any_grant)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    gnt_d            = gnt_q;
    ram_address_d    = ram_address_q;
    ram_byteenable_d = ram_byteenable_q;
    ram_writedata_d  = ram_writedata_q;
    ram_write_d      = ram_write_q;
    ram_cs_d         = ram_cs_q;
    ack_d            = '0;
    rvalid_d         = '0;
    rdata_d          = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          gnt_d            = pick_idx;
          ram_address_d    = bus.req_address[pick_idx*ADDR_W +: ADDR_W];
          ram_write_d      = bus.req_write[pick_idx];
          ram_byteenable_d = bus.req_write[pick_idx] ? bus.req_byteenable[pick_idx*BE_W +: BE_W] : '1;
          ram_writedata_d  = bus.req_writedata[pick_idx*DATA_W +: DATA_W];
          ram_cs_d         = 1'b1;
          ack_d            = pick_oh;
          state_d          = ACCESS;
        end
      end
      ACCESS: begin
        ram_cs_d     = 1'b0;
        ram_write_d  = 1'b0;
        last_grant_d = gnt_q;
        state_d      = ram_write_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        // RAM read data is combinational from its registered address: valid this cycle.
        rdata_d  = bus.ram_readdata;
        rvalid_d = NUM_REQ'(1) << gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= IW'(NUM_REQ - 1);
      gnt_q            <= '0;
      ram_address_q    <= '0;
      ram_byteenable_q <= '0;
      ram_writedata_q  <= '0;
      ram_write_q      <= 1'b0;
      ram_cs_q         <= 1'b0;
      ack_q            <= '0;
      rvalid_q         <= '0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      gnt_q            <= gnt_d;
      ram_address_q    <= ram_address_d;
      ram_byteenable_q <= ram_byteenable_d;
      ram_writedata_q  <= ram_writedata_d;
      ram_write_q      <= ram_write_d;
      ram_cs_q         <= ram_cs_d;
      ack_q            <= ack_d;
      rvalid_q         <= rvalid_d;
      rdata_q          <= rdata_d;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.rvalid         = rvalid_q;
  assign bus.rdata          = rdata_q;
  assign bus.ram_address    = ram_address_q;
  assign bus.ram_byteenable = ram_byteenable_q;
  assign bus.ram_writedata  = ram_writedata_q;
  assign bus.ram_write      = ram_write_q;
  assign bus.ram_chipselect = ram_cs_q;

endmodule
